// File: rtl/score_pkg.sv
// Shared types for the multi-player score tracker: game state encoding.
package score_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } state_e;

endpackage

// File: rtl/score_channel.sv
// One player's score, alive flag and (with SCORE_STREAK_EN defined) streak timer.
// Exposes next-state score/alive so the top can decide win/all-dead on the same edge.
module score_channel
    import score_pkg::*;
#(
    parameter int SCORE_W       = 7,
    parameter int MAX_SCORE     = 50,
    parameter int STREAK_WINDOW = 16
) (
    input  logic               clk,
    input  logic               nRst,
    input  logic               clear_i,
    input  logic               active_i,
    input  logic               good_i,
    input  logic               bad_i,
    output logic [SCORE_W-1:0] score_o,
    output logic               alive_o,
    output logic [SCORE_W-1:0] score_nxt_o,
    output logic               alive_nxt_o
);

    localparam logic [SCORE_W-1:0] MAX_V   = SCORE_W'(MAX_SCORE);
    localparam logic [SCORE_W:0]   MAX_EXT = (SCORE_W + 1)'(MAX_SCORE);

    logic [SCORE_W-1:0] score_q, score_d;
    logic               alive_q, alive_d;
    logic [SCORE_W-1:0] inc;
    logic [SCORE_W:0]   sum;
    logic               hit;

    // A scoring hit needs a live player in PLAY; a same-cycle fatal collision wins.
    assign hit = active_i && alive_q && good_i && !bad_i;

`ifdef SCORE_STREAK_EN
    localparam int TMR_W = $clog2(STREAK_WINDOW + 1);

    logic [TMR_W-1:0] tmr_q;

    // Timer nonzero means the previous hit was within STREAK_WINDOW cycles.
    assign inc = (tmr_q != '0) ? SCORE_W'(2) : SCORE_W'(1);

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            tmr_q <= '0;
        end else if (clear_i) begin
            tmr_q <= '0;
        end else if (hit) begin
            tmr_q <= TMR_W'(STREAK_WINDOW);
        end else if (tmr_q != '0) begin
            tmr_q <= tmr_q - 1'b1;
        end
    end
`else
    assign inc = SCORE_W'(1);
`endif

    assign sum = {1'b0, score_q} + {1'b0, inc};

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        score_d = score_q;
        alive_d = alive_q;
        if (clear_i) begin
            score_d = '0;
            alive_d = 1'b1;
        end else if (active_i && alive_q) begin
            if (bad_i) begin
                alive_d = 1'b0;
            end else if (good_i) begin
                score_d = (sum >= MAX_EXT) ? MAX_V : sum[SCORE_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!nRst) begin
            score_q <= '0;
            alive_q <= 1'b0;
        end else begin
            score_q <= score_d;
            alive_q <= alive_d;
        end
    end

    assign score_o     = score_q;
    assign alive_o     = alive_q;
    assign score_nxt_o = score_d;
    assign alive_nxt_o = alive_d;

endmodule

// File: rtl/multi_score_tracker.sv
// Multi-player score tracker: game FSM, winner select and high score over N score_channel lanes.
// Optional SCORE_STREAK_EN: back-to-back hits within STREAK_WINDOW cycles score 2.
module multi_score_tracker
    import score_pkg::*;
#(
    parameter int N_PLAYERS     = 2,
    parameter int SCORE_W       = 7,
    parameter int MAX_SCORE     = 50,
    parameter int STREAK_WINDOW = 16
) (
    input  logic                                               clk,
    input  logic                                               nRst,
    input  logic                                               start,
    input  logic [N_PLAYERS-1:0]                               good_coll,
    input  logic [N_PLAYERS-1:0]                               bad_coll,
    output logic [N_PLAYERS*SCORE_W-1:0]                       curr_score,
    output logic [N_PLAYERS-1:0]                               alive,
    output logic [SCORE_W-1:0]                                 high_score,
    output logic [STATE_W-1:0]                                 state,
    output logic                                               game_over,
    output logic [(N_PLAYERS > 1 ? $clog2(N_PLAYERS) : 1)-1:0] winner,
    output logic                                               winner_valid
);

    localparam int WIN_W = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1;
    localparam logic [SCORE_W-1:0] MAX_V = SCORE_W'(MAX_SCORE);

    if (MAX_SCORE >= 2 ** SCORE_W) begin : g_bad_max
        $error("MAX_SCORE must be below 2**SCORE_W");
    end
    if (N_PLAYERS < 1 || N_PLAYERS > 8) begin : g_bad_players
        $error("N_PLAYERS must be in 1..8");
    end

    state_e             state_q;
    logic               game_over_q;
    logic [SCORE_W-1:0] high_q;
    logic [WIN_W-1:0]   winner_q;
    logic               winner_valid_q;

    logic               clear, active;
    logic [SCORE_W-1:0] score_nxt [N_PLAYERS];
    logic [N_PLAYERS-1:0] alive_nxt;

    assign clear  = start && (state_q == IDLE || state_q == OVER);
    assign active = (state_q == PLAY);

    for (genvar i = 0; i < N_PLAYERS; i++) begin : g_ch
        score_channel #(
            .SCORE_W      (SCORE_W),
            .MAX_SCORE    (MAX_SCORE),
            .STREAK_WINDOW(STREAK_WINDOW)
        ) u_ch (
            .clk        (clk),
            .nRst       (nRst),
            .clear_i    (clear),
            .active_i   (active),
            .good_i     (good_coll[i]),
            .bad_i      (bad_coll[i]),
            .score_o    (curr_score[i*SCORE_W +: SCORE_W]),
            .alive_o    (alive[i]),
            .score_nxt_o(score_nxt[i]),
            .alive_nxt_o(alive_nxt[i])
        );
    end

    logic               win_found;
    logic [WIN_W-1:0]   win_idx;
    logic [SCORE_W-1:0] max_nxt;

    // Scan high to low so the lowest winning index is the one kept.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        max_nxt   = '0;
        for (int i = N_PLAYERS - 1; i >= 0; i--) begin
            if (score_nxt[i] == MAX_V) begin
                win_found = 1'b1;
                win_idx   = WIN_W'(i);
            end
            if (score_nxt[i] > max_nxt) begin
                max_nxt = score_nxt[i];
            end
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q        <= IDLE;
            game_over_q    <= 1'b0;
            high_q         <= '0;
            winner_q       <= '0;
            winner_valid_q <= 1'b0;
        end else begin
            if (max_nxt > high_q) begin
                high_q <= max_nxt;
            end
            case (state_q)
                IDLE, OVER: begin
                    if (start) begin
                        state_q        <= PLAY;
                        game_over_q    <= 1'b0;
                        winner_q       <= '0;
                        winner_valid_q <= 1'b0;
                    end
                end
                PLAY: begin
                    if (win_found) begin
                        state_q        <= OVER;
                        game_over_q    <= 1'b1;
                        winner_q       <= win_idx;
                        winner_valid_q <= 1'b1;
                    end else if (alive_nxt == '0) begin
                        state_q        <= OVER;
                        game_over_q    <= 1'b1;
                        winner_q       <= '0;
                        winner_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    game_over_q <= 1'b0;
                end
            endcase
        end
    end

    assign state        = state_q;
    assign game_over    = game_over_q;
    assign high_score   = high_q;
    assign winner       = winner_q;
    assign winner_valid = winner_valid_q;

endmodule

// File: tb/tb_multi_score_tracker.sv
// Directed self-checking bench for multi_score_tracker (2 players, 7-bit scores, MAX 50).
module tb_multi_score_tracker;

    logic        clk = 1'b0;
    logic        nRst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  good_coll = '0;
    logic [1:0]  bad_coll = '0;
    logic [13:0] curr_score;
    logic [1:0]  alive;
    logic [6:0]  high_score;
    logic [1:0]  state;
    logic        game_over;
    logic [0:0]  winner;
    logic        winner_valid;

    int total = 0;
    int bad   = 0;

    multi_score_tracker dut (
        .clk         (clk),
        .nRst        (nRst),
        .start       (start),
        .good_coll   (good_coll),
        .bad_coll    (bad_coll),
        .curr_score  (curr_score),
        .alive       (alive),
        .high_score  (high_score),
        .state       (state),
        .game_over   (game_over),
        .winner      (winner),
        .winner_valid(winner_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] sc(input int i);
        return curr_score[i*7 +: 7];
    endfunction

    // Drive one cycle of inputs on the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input logic [1:0] g, input logic [1:0] b, input logic s);
        @(negedge clk);
        good_coll = g;
        bad_coll  = b;
        start     = s;
        @(posedge clk);
        #1;
        good_coll = '0;
        bad_coll  = '0;
        start     = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(2'b00, 2'b00, 1'b0);
    endtask

    // Assert reset between clock edges so only an asynchronous reset clears the outputs in time.
    task automatic reset_pulse(input string tag);
        @(negedge clk);
        #2 nRst = 1'b0;
        #1;
        check({tag, "_state"}, state, 0);
        check({tag, "_scores"}, curr_score, 0);
        check({tag, "_alive"}, alive, 0);
        check({tag, "_high"}, high_score, 0);
        check({tag, "_winner"}, {winner_valid, winner}, 0);
        check({tag, "_over"}, game_over, 0);
        @(negedge clk);
        nRst = 1'b1;
    endtask

    initial begin
        #1;
        reset_pulse("rst0");

`ifdef SCORE_STREAK_EN
        step(2'b00, 2'b00, 1'b1);
        step(2'b01, 2'b00, 1'b0);
        check("streak_first", sc(0), 1);
        idle(4);
        step(2'b01, 2'b00, 1'b0);
        check("streak_5apart", sc(0), 3);
        idle(19);
        step(2'b01, 2'b00, 1'b0);
        check("streak_20apart", sc(0), 4);
        for (int k = 0; k < 22; k++) step(2'b01, 2'b00, 1'b0);
        check("streak_48", sc(0), 48);
        idle(17);
        step(2'b01, 2'b00, 1'b0);
        check("streak_49", sc(0), 49);
        check("streak_49_state", state, 1);
        step(2'b01, 2'b00, 1'b0);
        check("streak_sat", sc(0), 50);
        check("streak_over", state, 2);
        check("streak_winner", {winner_valid, winner}, 2'b10);
`else
        // Three hits on player 0; a start mid-game must not clear them.
        step(2'b00, 2'b00, 1'b1);
        check("start_state", state, 1);
        check("start_alive", alive, 2'b11);
        for (int k = 0; k < 3; k++) step(2'b01, 2'b00, 1'b0);
        check("p0_score3", sc(0), 3);
        check("p0_high3", high_score, 3);
        check("p0_state", state, 1);
        step(2'b00, 2'b00, 1'b1);
        check("start_in_play", sc(0), 3);

        // Player 1 climbs to the winning score.
        for (int k = 0; k < 49; k++) step(2'b10, 2'b00, 1'b0);
        check("p1_49", sc(1), 49);
        check("p1_49_state", state, 1);
        check("p1_49_valid", winner_valid, 0);
        step(2'b10, 2'b00, 1'b0);
        check("p1_win_state", state, 2);
        check("p1_win_winner", winner, 1);
        check("p1_win_valid", winner_valid, 1);
        check("p1_win_over", game_over, 1);
        check("p1_win_high", high_score, 50);
        step(2'b11, 2'b11, 1'b0);
        check("over_hold", curr_score, {7'd50, 7'd3});
        check("over_alive", alive, 2'b11);
        check("over_state", state, 2);

        // Bad beats good; dead player ignores hits; last death ends the game without a winner.
        step(2'b00, 2'b00, 1'b1);
        check("restart_scores", curr_score, 0);
        check("restart_valid", winner_valid, 0);
        for (int k = 0; k < 7; k++) step(2'b01, 2'b00, 1'b0);
        step(2'b01, 2'b01, 1'b0);
        check("badgood_score", sc(0), 7);
        check("badgood_alive", alive, 2'b10);
        step(2'b01, 2'b00, 1'b0);
        check("dead_ignored", sc(0), 7);
        step(2'b00, 2'b10, 1'b0);
        check("alldead_state", state, 2);
        check("alldead_valid", winner_valid, 0);
        check("alldead_alive", alive, 2'b00);

        // High score survives a new game but not a reset.
        reset_pulse("rst1");
        step(2'b00, 2'b00, 1'b1);
        for (int k = 0; k < 12; k++) step(2'b01, 2'b00, 1'b0);
        check("g1_high", high_score, 12);
        step(2'b00, 2'b11, 1'b0);
        check("g1_over", state, 2);
        step(2'b00, 2'b00, 1'b1);
        check("g2_cleared", curr_score, 0);
        for (int k = 0; k < 5; k++) step(2'b10, 2'b00, 1'b0);
        check("g2_score", sc(1), 5);
        check("g2_high", high_score, 12);
        reset_pulse("rst2");

        // Simultaneous win: lowest index takes it.
        step(2'b00, 2'b00, 1'b1);
        for (int k = 0; k < 50; k++) step(2'b11, 2'b00, 1'b0);
        check("tie_scores", curr_score, {7'd50, 7'd50});
        check("tie_state", state, 2);
        check("tie_winner", {winner_valid, winner}, 2'b10);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
